serial_multiplier: RTL

//  Iterative digit-serial multiplier for 255-bit Curve25519 field operands.

---
 rtl/curve25519_pkg.sv | 21 ++
 rtl/mul_digit_pp.sv | 26 ++
 rtl/serial_multiplier.sv | 120 ++++++++++++
 3 files changed

// File: rtl/curve25519_pkg.sv
// Shared Curve25519 constants and multiplier FSM encoding.
package curve25519_pkg;

  localparam int WIDE_OP  = 255;
  localparam int WIDE_OUT = 512;

  // p = 2^255 - 19: all ones except the low five bits, which are 5'b01101.
  localparam logic [WIDE_OP-1:0] PRIME = {{(WIDE_OP-5){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULT     = 2'b01,
    FINALIZE = 2'b10
  } state_t;

  // Number of digit-serial steps needed to consume an operand of op_w bits.
  function automatic int num_digits(input int op_w, input int digit);
    return (op_w + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// Combinational WIDE_OP x DIGIT partial-product generator.
module mul_digit_pp #(
  parameter int WIDE_OP = 255,
  parameter int DIGIT   = 1
) (
  input  logic [WIDE_OP-1:0]       i_a,
  input  logic [DIGIT-1:0]         i_d,
  output logic [WIDE_OP+DIGIT-1:0] o_pp
);

  generate
    if (DIGIT == 1) begin : g_and
      // A single multiplier bit just gates the multiplicand.
      assign o_pp = {1'b0, i_a & {WIDE_OP{i_d[0]}}};
    end else begin : g_sum
      // Shift-and-add over the digit bits; the result always fits WIDE_OP+DIGIT.
      always_comb begin
        o_pp = '0;
        for (int j = 0; j < DIGIT; j++) begin
          if (i_d[j]) o_pp = o_pp + ({{DIGIT{1'b0}}, i_a} << j);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/serial_multiplier.sv
// Digit-serial, MSB-first multiplier producing the full unreduced A*B.
//
// Control contract: start is a request that is only honoured in IDLE; there
// is no backpressure. done is a one-cycle pulse in the cycle product changes,
// and product holds its value until the next done. busy is high from the
// cycle after start is accepted until the cycle before done.
module serial_multiplier
  import curve25519_pkg::*;
#(
  parameter int WIDE_OP  = curve25519_pkg::WIDE_OP,
  parameter int WIDE_OUT = curve25519_pkg::WIDE_OUT,
  parameter int DIGIT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDE_OP-1:0]  A,
  input  logic [WIDE_OP-1:0]  B,
  output logic [WIDE_OUT-1:0] product,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state
);

  localparam int N     = num_digits(WIDE_OP, DIGIT);
  localparam int PAD_W = N * DIGIT;
  localparam int PP_W  = WIDE_OP + DIGIT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t              r_state;
  state_t              w_next;
  logic [WIDE_OP-1:0]  r_a;
  logic [PAD_W-1:0]    r_b;
  logic [WIDE_OUT-1:0] r_acc;
  logic [WIDE_OUT-1:0] r_product;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;

  logic                w_load;
  logic                w_step;
  logic                w_fin;
  logic [PP_W-1:0]     w_pp;
  logic [WIDE_OUT-1:0] w_acc_next;

  // Partial product of the multiplicand with the current top digit of B.
  mul_digit_pp #(
    .WIDE_OP(WIDE_OP),
    .DIGIT  (DIGIT)
  ) u_pp (
    .i_a (r_a),
    .i_d (r_b[PAD_W-1 -: DIGIT]),
    .o_pp(w_pp)
  );

  assign w_acc_next = (r_acc << DIGIT) + WIDE_OUT'(w_pp);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and datapath enables.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = MULT;
        end
      end
      MULT: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_next = FINALIZE;
      end
      FINALIZE: begin
        w_fin  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand, accumulator, counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_a   <= A;
        r_b   <= PAD_W'(B);
        r_acc <= '0;
        r_cnt <= CNT_LAST;
      end
      if (w_step) begin
        r_acc <= w_acc_next;
        r_b   <= r_b << DIGIT;
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_fin) r_product <= r_acc;
    end
  end

  assign product   = r_product;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule
